// File: rtl/bp_me_io_split_pkg.sv
// Shared types and the address decode for the I/O command splitter.
package bp_me_io_split_pkg;

    typedef enum logic {
        e_io_dest_host = 1'b0,
        e_io_dest_dev  = 1'b1
    } bp_io_dest_e;

    localparam int unsigned io_addr_max_width_lp = 64;

    // Offset from the device base is taken modulo 2^width, so addresses below base wrap high.
    function automatic bp_io_dest_e io_dest_decode(
        input logic [io_addr_max_width_lp-1:0] addr,
        input logic [io_addr_max_width_lp-1:0] base,
        input logic [io_addr_max_width_lp-1:0] size,
        input int unsigned                     width
    );
        logic [io_addr_max_width_lp-1:0] mask;
        logic [io_addr_max_width_lp-1:0] offset;
        mask   = (width >= io_addr_max_width_lp) ? '1
               : ((io_addr_max_width_lp'(1) << width) - io_addr_max_width_lp'(1));
        offset = (addr - base) & mask;
        return (offset < size) ? e_io_dest_dev : e_io_dest_host;
    endfunction

endpackage

// File: rtl/bp_me_io_order_fifo.sv
// One-bit ring FIFO recording the destination of each in-flight command.
module bp_me_io_order_fifo #(
    parameter int unsigned depth_p = 4
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic push_i,
    input  logic data_i,
    input  logic pop_i,
    output logic data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned aw_lp = $clog2(depth_p);

    logic [depth_p-1:0] mem_q;
    logic [aw_lp:0]     wr_q;
    logic [aw_lp:0]     rd_q;
    logic               do_push;
    logic               do_pop;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Extra pointer bit distinguishes full from empty when the low bits match.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q[aw_lp-1:0]] <= data_i;
                wr_q                   <= wr_q + (aw_lp+1)'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + (aw_lp+1)'(1);
            end
        end
    end

    assign data_o  = mem_q[rd_q[aw_lp-1:0]];
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[aw_lp] != rd_q[aw_lp]) && (wr_q[aw_lp-1:0] == rd_q[aw_lp-1:0]);

endmodule

// File: rtl/bp_me_io_cmd_splitter.sv
// Steers core I/O commands to host or device by address and returns responses in command order.
module bp_me_io_cmd_splitter
    import bp_me_io_split_pkg::*;
#(
    parameter int unsigned             msg_width_p   = 128,
    parameter int unsigned             paddr_width_p = 40,
    parameter int unsigned             addr_lsb_p    = 0,
    parameter logic [paddr_width_p-1:0] dev_base_p   = 40'h00_0020_0000,
    parameter logic [paddr_width_p-1:0] dev_size_p   = 40'h00_0001_0000,
    parameter int unsigned             outstanding_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [msg_width_p-1:0] io_cmd_i,
    input  logic                   io_cmd_v_i,
    output logic                   io_cmd_ready_o,
    output logic [msg_width_p-1:0] io_resp_o,
    output logic                   io_resp_v_o,
    input  logic                   io_resp_yumi_i,
    output logic [msg_width_p-1:0] host_cmd_o,
    output logic                   host_cmd_v_o,
    input  logic                   host_cmd_ready_i,
    input  logic [msg_width_p-1:0] host_resp_i,
    input  logic                   host_resp_v_i,
    output logic                   host_resp_yumi_o,
    output logic [msg_width_p-1:0] dev_cmd_o,
    output logic                   dev_cmd_v_o,
    input  logic                   dev_cmd_ready_i,
    input  logic [msg_width_p-1:0] dev_resp_i,
    input  logic                   dev_resp_v_i,
    output logic                   dev_resp_yumi_o,
    output logic                   err_o
);

    localparam int unsigned cnt_width_lp = $clog2(outstanding_p + 1);

    logic [paddr_width_p-1:0] cmd_addr;
    bp_io_dest_e              cmd_dest;
    bp_io_dest_e              head_dest;
    logic                     head_bit;
    logic                     full;
    logic                     empty;
    logic                     fire;
    logic                     pop;
    logic [cnt_width_lp-1:0]  host_cnt_q;
    logic [cnt_width_lp-1:0]  dev_cnt_q;

    assign cmd_addr   = io_cmd_i[addr_lsb_p +: paddr_width_p];
    assign cmd_dest   = io_dest_decode(64'(cmd_addr), 64'(dev_base_p), 64'(dev_size_p), paddr_width_p);
    assign head_dest  = bp_io_dest_e'(head_bit);
    assign host_cmd_o = io_cmd_i;
    assign dev_cmd_o  = io_cmd_i;

    // Command steering and response muxing; every handshake is held low during reset.
    always_comb begin
        io_cmd_ready_o   = 1'b0;
        host_cmd_v_o     = 1'b0;
        dev_cmd_v_o      = 1'b0;
        io_resp_v_o      = 1'b0;
        io_resp_o        = host_resp_i;
        host_resp_yumi_o = 1'b0;
        dev_resp_yumi_o  = 1'b0;
        fire             = 1'b0;
        pop              = 1'b0;
        if (reset_n_i) begin
            io_cmd_ready_o = ~full & ((cmd_dest == e_io_dest_dev) ? dev_cmd_ready_i : host_cmd_ready_i);
            host_cmd_v_o   = io_cmd_v_i & (cmd_dest == e_io_dest_host) & ~full;
            dev_cmd_v_o    = io_cmd_v_i & (cmd_dest == e_io_dest_dev) & ~full;
            fire           = io_cmd_v_i & io_cmd_ready_o;
            if (head_dest == e_io_dest_dev) begin
                io_resp_o = dev_resp_i;
            end
            io_resp_v_o      = ~empty & ((head_dest == e_io_dest_dev) ? dev_resp_v_i : host_resp_v_i);
            pop              = io_resp_yumi_i & ~empty;
            host_resp_yumi_o = pop & (head_dest == e_io_dest_host);
            dev_resp_yumi_o  = pop & (head_dest == e_io_dest_dev);
        end
    end

    bp_me_io_order_fifo #(
        .depth_p(outstanding_p)
    ) order_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .push_i   (fire),
        .data_i   (1'(cmd_dest)),
        .pop_i    (pop),
        .data_o   (head_bit),
        .full_o   (full),
        .empty_o  (empty)
    );

    // Per-port outstanding counts; the FIFO full check keeps them from wrapping.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            host_cnt_q <= '0;
            dev_cnt_q  <= '0;
        end else begin
            if (host_cmd_v_o & fire & ~host_resp_yumi_o) begin
                host_cnt_q <= host_cnt_q + cnt_width_lp'(1);
            end else if (host_resp_yumi_o & ~(host_cmd_v_o & fire)) begin
                host_cnt_q <= host_cnt_q - cnt_width_lp'(1);
            end
            if (dev_cmd_v_o & fire & ~dev_resp_yumi_o) begin
                dev_cnt_q <= dev_cnt_q + cnt_width_lp'(1);
            end else if (dev_resp_yumi_o & ~(dev_cmd_v_o & fire)) begin
                dev_cnt_q <= dev_cnt_q - cnt_width_lp'(1);
            end
        end
    end

    // Sticky flag for a response with nothing outstanding on its port.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_o <= 1'b0;
        end else if ((host_resp_v_i && (host_cnt_q == '0)) || (dev_resp_v_i && (dev_cnt_q == '0))) begin
            err_o <= 1'b1;
        end
    end

endmodule
